// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx serializer between N_REQ byte requesters.
// The serializer gives no completion feedback, so each frame is timed locally with a
// down-counter, followed by a short guard gap before the next grant.
//
//  state | meaning
//  IDLE  | waiting for any req_valid; grants on the first edge one is seen
//  HOLD  | frame on the line; tx_data held, counting FRAME_CYCLES down to zero
//  GAP   | guard interval after the frame; counting GUARD_CYCLES down to zero
module uart_tx_arbiter #(
   parameter int N_REQ        = 4,
   parameter int BASE_FREQ    = 50_000_000,
   parameter int BAUDRATE     = 115_200,
   parameter int FRAME_BITS   = 11,
   parameter int GUARD_CYCLES = 2
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic [N_REQ-1:0]   i_req_valid,
   input  logic [8*N_REQ-1:0] i_req_data,
   output logic [N_REQ-1:0]   o_req_ack,
   output logic [2:0]         o_grant_id,
   output logic [7:0]         o_tx_data,
   output logic               o_tx_send,
   output logic               o_busy,
   output logic               o_frame_done
);

   localparam int CLKS_PER_BIT = BASE_FREQ / BAUDRATE;
   localparam int FRAME_CYCLES = FRAME_BITS * CLKS_PER_BIT;
   localparam int CNT_MAX      = (FRAME_CYCLES > GUARD_CYCLES) ? FRAME_CYCLES : GUARD_CYCLES;
   localparam int CNT_W        = $clog2(CNT_MAX + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_HOLD = 2'd1;
   localparam logic [1:0] S_GAP  = 2'd2;

   logic [1:0]       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [2:0]       r_rr_ptr;
   logic [N_REQ-1:0] r_req_ack;
   logic [2:0]       r_grant_id;
   logic [7:0]       r_tx_data;
   logic             r_tx_send;
   logic             r_busy;
   logic             r_frame_done;

   logic             w_any;
   logic [2:0]       w_win;
   logic [7:0]       w_win_data;
   logic [N_REQ-1:0] w_win_onehot;

   // Pick the first pending requester after the last winner, wrapping modulo N_REQ.
   always_comb begin
      w_any = 1'b0;
      w_win = 3'd0;
      for (int k = 1; k <= N_REQ; k++) begin
         if (!w_any && i_req_valid[(int'(r_rr_ptr) + k) % N_REQ]) begin
            w_any = 1'b1;
            w_win = 3'((int'(r_rr_ptr) + k) % N_REQ);
         end
      end
   end

   // Winner's byte and one-hot acknowledge pattern.
   always_comb begin
      w_win_data   = i_req_data[8*int'(w_win) +: 8];
      w_win_onehot = '0;
      w_win_onehot[w_win] = 1'b1;
   end

   // Sequencer: grant in IDLE, time the frame in HOLD, then the guard gap.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_rr_ptr     <= 3'(N_REQ - 1);
         r_req_ack    <= '0;
         r_grant_id   <= 3'd0;
         r_tx_data    <= 8'd0;
         r_tx_send    <= 1'b0;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_req_ack    <= '0;
         r_tx_send    <= 1'b0;
         r_frame_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_req_ack    <= w_win_onehot;
                  r_grant_id   <= w_win;
                  r_rr_ptr     <= w_win;
                  r_tx_data    <= w_win_data;
                  r_tx_send    <= 1'b1;
                  r_cnt        <= CNT_W'(FRAME_CYCLES - 1);
                  r_busy       <= 1'b1;
                  // a one-cycle frame would already be on its last HOLD cycle
                  r_frame_done <= (FRAME_CYCLES == 1);
                  r_state      <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (r_cnt == '0) begin
                  r_cnt   <= CNT_W'(GUARD_CYCLES - 1);
                  r_state <= S_GAP;
               end else begin
                  r_cnt        <= r_cnt - 1'b1;
                  // registered so the pulse lands on the cycle where cnt reads zero
                  r_frame_done <= (r_cnt == CNT_W'(1));
               end
            end
            S_GAP: begin
               if (r_cnt == '0) begin
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign o_req_ack    = r_req_ack;
   assign o_grant_id   = r_grant_id;
   assign o_tx_data    = r_tx_data;
   assign o_tx_send    = r_tx_send;
   assign o_busy       = r_busy;
   assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: random requesters against a timeline-based reference model.
// The model records the cycle of each grant and derives every output from it arithmetically.
module tb_uart_tx_arbiter;

   localparam int N     = 4;
   localparam int FRAME = 44;
   localparam int GUARD = 2;
   localparam int NCYC  = 4000;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [N-1:0]  req_valid = '1;
   logic [8*N-1:0] req_data = '0;
   logic [N-1:0]  req_ack;
   logic [2:0]    grant_id;
   logic [7:0]    tx_data;
   logic          tx_send;
   logic          busy;
   logic          frame_done;

   int total = 0;
   int bad   = 0;

   uart_tx_arbiter #(
      .N_REQ(N), .BASE_FREQ(40), .BAUDRATE(10), .FRAME_BITS(11), .GUARD_CYCLES(GUARD)
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .i_req_data(req_data),
      .o_req_ack(req_ack), .o_grant_id(grant_id), .o_tx_data(tx_data),
      .o_tx_send(tx_send), .o_busy(busy), .o_frame_done(frame_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp, input int cyc);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   // reference model state
   bit          granted;
   int          last_s;
   int          m_w;
   logic [7:0]  m_data;
   int          rr;
   int          next_sample;
   logic [N-1:0] ack_seen;

   initial begin
      bit rst_now;
      int p;
      logic [N-1:0] e_ack;
      granted = 0; last_s = 0; m_w = 0; m_data = 0; rr = N - 1; next_sample = 0;
      ack_seen = '0;
      for (int i = 0; i < N; i++) req_data[8*i +: 8] = 8'($urandom);
      for (int n = 0; n < NCYC; n++) begin
         @(posedge clk); #1;
         rst_now = (n < 3) || (n == 24) || (n > 10 && $urandom_range(0, 999) == 0);
         rst_n = !rst_now;
         p = (n < 800) ? 100 : 3;
         if (n >= 3) begin
            for (int i = 0; i < N; i++) begin
               if (req_valid[i] && ack_seen[i]) req_valid[i] = 1'b0;
               else if (req_valid[i] && n > 3 && $urandom_range(0, 299) == 0) req_valid[i] = 1'b0;
               if (!req_valid[i] && !ack_seen[i] && $urandom_range(0, 99) < p) begin
                  req_valid[i] = 1'b1;
                  req_data[8*i +: 8] = 8'($urandom);
               end
            end
         end
         @(negedge clk);
         if (rst_now) begin
            granted = 0; rr = N - 1; m_w = 0; m_data = 0; next_sample = n + 1;
         end
         e_ack = '0;
         if (granted && n == last_s + 1) e_ack[m_w] = 1'b1;
         check("req_ack",    32'(req_ack),    32'(e_ack), n);
         check("tx_send",    32'(tx_send),    32'(granted && n == last_s + 1), n);
         check("frame_done", 32'(frame_done), 32'(granted && n == last_s + FRAME), n);
         check("busy",       32'(busy),       32'(granted && n >= last_s + 1 && n <= last_s + FRAME + GUARD), n);
         check("grant_id",   32'(grant_id),   32'(m_w), n);
         check("tx_data",    32'(tx_data),    32'(m_data), n);
         ack_seen = req_ack;
         if (!rst_now && n >= next_sample && |req_valid) begin
            for (int k = 1; k <= N; k++) begin
               if (req_valid[(rr + k) % N]) begin
                  m_w = (rr + k) % N;
                  break;
               end
            end
            rr          = m_w;
            m_data      = req_data[8*m_w +: 8];
            granted     = 1;
            last_s      = n;
            next_sample = n + FRAME + GUARD + 1;
         end
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
